fetch_ctrl: RTL



---
 rtl/fetch_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding req/gnt/rvalid fetch at a time,
// responses buffered with their PC in a small FIFO, redirects flush stale work.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_IDLE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        issued_pc_q, issued_pc_d;
    logic               pend_q, pend_d;
    logic [31:0]        buf_instr_q [BUF_DEPTH];
    logic [31:0]        buf_instr_d [BUF_DEPTH];
    logic [31:0]        buf_pc_q    [BUF_DEPTH];
    logic [31:0]        buf_pc_d    [BUF_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               req_q, req_d;
    logic [31:0]        addr_q, addr_d;
    logic               valid_q, valid_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        ipc_q, ipc_d;

    logic               push;
    logic               pop;
    logic [31:0]        redir_pc;
    logic               unused_rpc_lsb;

    assign redir_pc       = {redirect_pc_i[31:2], 2'b00};
    assign unused_rpc_lsb = ^redirect_pc_i[1:0];

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = ipc_q;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        pend_d      = pend_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        req_d       = 1'b0;
        addr_d      = addr_q;
        valid_d     = 1'b0;
        instr_d     = instr_q;
        ipc_d       = ipc_q;
        push        = 1'b0;
        // A redirect flushes the buffer, so a coincident pop has no effect.
        pop         = (count_q != '0) && instr_ready_i && !redirect_i;

        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
                if (redirect_i) fetch_pc_d = redir_pc;
            end
            S_REQ: begin
                if (imem_gnt_i) begin
                    issued_pc_d = addr_q;
                    if (pend_q || redirect_i) begin
                        state_d    = S_DRAIN;
                        pend_d     = 1'b0;
                        fetch_pc_d = redirect_i ? redir_pc : fetch_pc_q;
                    end else begin
                        state_d    = S_WAIT;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (redirect_i) begin
                    pend_d     = 1'b1;
                    fetch_pc_d = redir_pc;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    fetch_pc_d = redir_pc;
                    state_d    = imem_rvalid_i ? S_REQ : S_DRAIN;
                end else if (imem_rvalid_i) begin
                    push    = 1'b1;
                    state_d = ((count_q + CNT_W'(1) - CNT_W'(pop)) < DEPTH_C) ? S_REQ : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (redirect_i) fetch_pc_d = redir_pc;
                if (imem_rvalid_i) state_d = S_REQ;
            end
            S_IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redir_pc;
                    state_d    = S_REQ;
                end else if ((count_q - CNT_W'(pop)) < DEPTH_C) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_BOOT;
        endcase

        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                buf_instr_d[wr_ptr_q] = imem_rdata_i;
                buf_pc_d[wr_ptr_q]    = issued_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // Address is captured on entry to REQ and held until the grant.
        req_d = (state_d == S_REQ);
        if ((state_d == S_REQ) && (state_q != S_REQ)) addr_d = fetch_pc_d;

        valid_d = (count_d != '0);
        if (count_d != '0) begin
            instr_d = buf_instr_d[rd_ptr_d];
            ipc_d   = buf_pc_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_BOOT;
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= RESET_PC;
            pend_q      <= 1'b0;
            buf_instr_q <= '{default: '0};
            buf_pc_q    <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            ipc_q       <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            pend_q      <= pend_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            ipc_q       <= ipc_d;
        end
    end

endmodule
